// File: rtl/fpu_serial_rx_if.sv
// Byte/word delivery bus between the host-link UART receiver and the FPU operand loader.
// The receiver (master) drives the byte/word outputs and flags; the loader (slave) drives word_ready.
interface fpu_serial_rx_if;
    logic [7:0]  byte_data;
    logic        byte_strobe;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        frame_err;
    logic        overrun;

    modport master (
        output byte_data,
        output byte_strobe,
        output word_data,
        output word_valid,
        output frame_err,
        output overrun,
        input  word_ready
    );

    modport slave (
        input  byte_data,
        input  byte_strobe,
        input  word_data,
        input  word_valid,
        input  frame_err,
        input  overrun,
        output word_ready
    );
endinterface

// File: rtl/fpu_serial_rx.sv
// 8N1 UART receiver for the FPU host link: assembles 4 little-endian bytes into a
// 32-bit operand word and hands it over on a valid/ready handshake.
module fpu_serial_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           serial1_rx,
    input  logic           flush,
    fpu_serial_rx_if.master rx_bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [23:0]      asm_q, asm_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_strobe_q, byte_strobe_d;
    logic [31:0]      word_data_q, word_data_d;
    logic             word_valid_q, word_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             good_byte;
    logic             word_done;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= serial1_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            baud_q        <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_cnt_q    <= '0;
            asm_q         <= '0;
            byte_data_q   <= '0;
            byte_strobe_q <= 1'b0;
            word_data_q   <= '0;
            word_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_cnt_q    <= byte_cnt_d;
            asm_q         <= asm_d;
            byte_data_q   <= byte_data_d;
            byte_strobe_q <= byte_strobe_d;
            word_data_q   <= word_data_d;
            word_valid_q  <= word_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_cnt_d    = byte_cnt_q;
        asm_d         = asm_q;
        byte_data_d   = byte_data_q;
        byte_strobe_d = 1'b0;
        word_data_d   = word_data_q;
        word_valid_d  = word_valid_q;
        frame_err_d   = 1'b0;
        overrun_d     = 1'b0;
        good_byte     = 1'b0;
        word_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end
            // Re-check the start bit at its centre to reject short glitches.
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            // Leaving at the stop-bit centre gives half a bit of slack for back-to-back frames.
            STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d = '0;
                    if (rx_s_q) begin
                        good_byte = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        byte_cnt_d  = '0;
                        state_d     = WAIT_HI;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (good_byte) begin
            byte_data_d   = shift_q;
            byte_strobe_d = 1'b1;
            byte_cnt_d    = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[7:0]   = shift_q;
                2'd1:    asm_d[15:8]  = shift_q;
                2'd2:    asm_d[23:16] = shift_q;
                default: ;
            endcase
        end

        word_done = good_byte && (byte_cnt_q == 2'd3) && !flush;

        if (word_valid_q && rx_bus.word_ready) begin
            word_valid_d = 1'b0;
        end

        // A held, unconsumed word has priority; a new one arriving behind it is dropped.
        if (word_done) begin
            if (!word_valid_q || rx_bus.word_ready) begin
                word_data_d  = {shift_q, asm_q};
                word_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (flush) begin
            byte_cnt_d = '0;
        end
    end

    assign rx_bus.byte_data   = byte_data_q;
    assign rx_bus.byte_strobe = byte_strobe_q;
    assign rx_bus.word_data   = word_data_q;
    assign rx_bus.word_valid  = word_valid_q;
    assign rx_bus.frame_err   = frame_err_q;
    assign rx_bus.overrun     = overrun_q;

endmodule
